frame_write_gate: RTL

- Pixel-clock stage between the RGB/edge pixel sources and the SDRAM frame-buffer write FIFOs.
- Selects the RGB or edge stream, switching only at frame boundaries, and packs each pixel into the two 16-bit write words.
- Writes exactly H_ACT*V_ACT pixels per frame, truncating long frames and padding short ones with black, so write addresses never drift against the read side.

---
 rtl/frame_write_gate.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_write_gate.sv
// frame_write_gate
//   Pixel-clock stage between the RGB/edge pixel sources and the two SDRAM
//   frame-buffer write FIFOs. It picks one source per frame and packs each
//   pixel into two 16-bit write words. Every frame writes exactly
//   H_ACT*V_ACT pixels: long frames are truncated and short frames are
//   padded with black. This keeps write addresses aligned with the read side.
//
// Ports
//   iCLK, iRST_N          pixel clock, asynchronous active-low reset
//   iFVAL                 registered camera frame valid
//   iSEL                  raw source switch (1 = edge, 0 = RGB), asynchronous
//   iRGB_R/G/B, iRGB_DVAL RGB-source pixel and its valid
//   iEDG_R/G/B, iEDG_DVAL edge-source pixel and its valid
//   iTEST                 test-pattern request (only with the macro below)
//   oWR1_DATA             {1'b0, G[11:7], B[11:2]}
//   oWR2_DATA             {1'b0, G[6:2],  R[11:2]}
//   oWR                   write strobe shared by both FIFOs
//   oPIX_CNT              pixels written in the current frame
//   oFRAME_DONE           one-cycle pulse on the write that reaches TOTAL
//   oLONG, oSHORT, oSKIP  sticky error flags, cleared only by reset
//
// Build option
//   FRAME_WRITE_GATE_TESTPAT_EN: adds iTEST. When it is latched high at frame
//   start, the written data becomes a ramp derived from the pixel count.

module frame_write_gate #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CNT_W = 19
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iFVAL,
  input  logic             iSEL,
  input  logic [11:0]      iRGB_R,
  input  logic [11:0]      iRGB_G,
  input  logic [11:0]      iRGB_B,
  input  logic             iRGB_DVAL,
  input  logic [11:0]      iEDG_R,
  input  logic [11:0]      iEDG_G,
  input  logic [11:0]      iEDG_B,
  input  logic             iEDG_DVAL,
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
  input  logic             iTEST,
`endif
  output logic [15:0]      oWR1_DATA,
  output logic [15:0]      oWR2_DATA,
  output logic             oWR,
  output logic [CNT_W-1:0] oPIX_CNT,
  output logic             oFRAME_DONE,
  output logic             oLONG,
  output logic             oSHORT,
  output logic             oSKIP
);

  localparam int TOTAL = H_ACT * V_ACT;
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    PAD,
    SKIP
  } state_t;

  state_t state, state_next;

  logic sel_meta, sel_sync, sel_active, sel_next;
  logic fval_prev, fval_rise;
  logic skip_pending, skip_pending_next;

  logic [11:0] src_r, src_g, src_b;
  logic        src_dval;
  logic [11:0] pix_r, pix_g, pix_b;

  logic             wr_next, done_next;
  logic             long_next, short_next, skip_next;
  logic [15:0]      wr1_next, wr2_next;
  logic [CNT_W-1:0] cnt_next, cnt_inc, cnt_after;

`ifdef FRAME_WRITE_GATE_TESTPAT_EN
  logic       test_meta, test_sync, test_active, test_next;
  logic [9:0] ramp;
`endif

  // Synchronise the asynchronous switch levels and remember the previous
  // iFVAL. fval_prev resets to 1 so that iFVAL already high at reset
  // release is not mistaken for a frame start.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sel_meta  <= 1'b0;
      sel_sync  <= 1'b0;
      fval_prev <= 1'b1;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
      test_meta <= 1'b0;
      test_sync <= 1'b0;
`endif
    end else begin
      sel_meta  <= iSEL;
      sel_sync  <= sel_meta;
      fval_prev <= iFVAL;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
      test_meta <= iTEST;
      test_sync <= test_meta;
`endif
    end
  end

  assign fval_rise = iFVAL & ~fval_prev;
  assign cnt_inc   = oPIX_CNT + CNT_W'(1);

  // Only the stream chosen at frame start is considered. The other
  // stream, including its DVAL, is ignored completely.
  always_comb begin
    src_r    = sel_active ? iEDG_R : iRGB_R;
    src_g    = sel_active ? iEDG_G : iRGB_G;
    src_b    = sel_active ? iEDG_B : iRGB_B;
    src_dval = sel_active ? iEDG_DVAL : iRGB_DVAL;
  end

`ifdef FRAME_WRITE_GATE_TESTPAT_EN
  assign ramp = 10'(oPIX_CNT);
`endif

  // Pixel data that gets packed. In test-pattern builds it can be replaced
  // by a ramp taken from the count before the increment.
  always_comb begin
    pix_r = src_r;
    pix_g = src_g;
    pix_b = src_b;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
    if (test_active) begin
      pix_r = {ramp, 2'b00};
      pix_g = {ramp, 2'b00};
      pix_b = {ramp, 2'b00};
    end
`endif
  end

  // Frame FSM: next state and next output values. In ACTIVE, a pixel that
  // arrives on the same cycle that iFVAL falls is counted before the
  // end-of-frame decision. That is why the decision uses cnt_after.
  always_comb begin
    state_next        = state;
    sel_next          = sel_active;
    skip_pending_next = skip_pending;
    wr_next           = 1'b0;
    done_next         = 1'b0;
    wr1_next          = oWR1_DATA;
    wr2_next          = oWR2_DATA;
    cnt_next          = oPIX_CNT;
    cnt_after         = oPIX_CNT;
    long_next         = oLONG;
    short_next        = oSHORT;
    skip_next         = oSKIP;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
    test_next         = test_active;
`endif

    case (state)
      IDLE: begin
        if (fval_rise) begin
          sel_next   = sel_sync;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
          test_next  = test_sync;
`endif
          cnt_next   = '0;
          state_next = ACTIVE;
        end
      end

      ACTIVE: begin
        if (src_dval) begin
          if (oPIX_CNT != TOTAL_CNT) begin
            wr_next   = 1'b1;
            wr1_next  = {1'b0, pix_g[11:7], pix_b[11:2]};
            wr2_next  = {1'b0, pix_g[6:2], pix_r[11:2]};
            cnt_next  = cnt_inc;
            cnt_after = cnt_inc;
            done_next = (cnt_inc == TOTAL_CNT);
          end else begin
            long_next = 1'b1;
          end
        end
        if (!iFVAL) begin
          if (cnt_after == TOTAL_CNT) begin
            state_next = IDLE;
          end else begin
            short_next        = 1'b1;
            skip_pending_next = 1'b0;
            state_next        = PAD;
          end
        end
      end

      // Black fill up to TOTAL. A frame that starts during this fill cannot
      // be captured cleanly, so it is remembered and skipped as a whole.
      PAD: begin
        wr_next  = 1'b1;
        wr1_next = 16'h0000;
        wr2_next = 16'h0000;
        cnt_next = cnt_inc;
        if (fval_rise) begin
          skip_next         = 1'b1;
          skip_pending_next = 1'b1;
        end
        if (cnt_inc == TOTAL_CNT) begin
          done_next  = 1'b1;
          state_next = (skip_pending || fval_rise) ? SKIP : IDLE;
        end
      end

      SKIP: begin
        skip_pending_next = 1'b0;
        if (!iFVAL) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs. Outputs are registered so that writes
  // appear one cycle after their pixel.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= IDLE;
      sel_active   <= 1'b0;
      skip_pending <= 1'b0;
      oWR          <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oWR1_DATA    <= '0;
      oWR2_DATA    <= '0;
      oPIX_CNT     <= '0;
      oLONG        <= 1'b0;
      oSHORT       <= 1'b0;
      oSKIP        <= 1'b0;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
      test_active  <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      sel_active   <= sel_next;
      skip_pending <= skip_pending_next;
      oWR          <= wr_next;
      oFRAME_DONE  <= done_next;
      oWR1_DATA    <= wr1_next;
      oWR2_DATA    <= wr2_next;
      oPIX_CNT     <= cnt_next;
      oLONG        <= long_next;
      oSHORT       <= short_next;
      oSKIP        <= skip_next;
`ifdef FRAME_WRITE_GATE_TESTPAT_EN
      test_active  <= test_next;
`endif
    end
  end

endmodule
